// File: rtl/mult32_seq.sv
// Sequential 32x32 shift-and-add multiplier (signed/unsigned) built on two SHIFT32 barrel shifters.
// Latency: START sampled at E0, DONE and new HI/LO at E33 (BUSY for 33 cycles), next START at E34.
// No backpressure: START is ignored while BUSY. HI/LO hold the last product until the next writeback.
// Ports: CLK/RST (sync active-high), START/SnU/A/B in, HI/LO product out, BUSY/DONE status out.

// 32-bit barrel shifter: logical shift of d by s, left when lnr=1, right when lnr=0.
module shift32 (
    input  logic [31:0] d,
    input  logic [4:0]  s,
    input  logic        lnr,
    output logic [31:0] y
);
    always_comb begin
        y = lnr ? (d << s) : (d >> s);
    end
endmodule

module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnU,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // One iteration: 33-bit partial sum, then {C,ACC,Q} >> 1.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_shr;
    logic [WIDTH-1:0] q_shr;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
    end

    shift32 u_shift_acc (
        .d   (sum[WIDTH-1:0]),
        .s   (5'd1),
        .lnr (1'b0),
        .y   (acc_shr)
    );

    shift32 u_shift_q (
        .d   (q_q),
        .s   (5'd1),
        .lnr (1'b0),
        .y   (q_shr)
    );

    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        prod    = {acc_q, q_q};

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    // Magnitudes: 0x80000000 negates to itself, which read as unsigned is 2^31.
                    m_d     = (SnU && A[WIDTH-1]) ? (~A + 1'b1) : A;
                    q_d     = (SnU && B[WIDTH-1]) ? (~B + 1'b1) : B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = SnU & (A[WIDTH-1] ^ B[WIDTH-1]);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Carry enters ACC[31]; the bit shifted out of ACC enters Q[31].
                acc_d = acc_shr | {sum[WIDTH], {(WIDTH-1){1'b0}}};
                q_d   = q_shr   | {sum[0],     {(WIDTH-1){1'b0}}};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (neg_q) begin
                    prod = ~{acc_q, q_q} + 1'b1;
                end
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;
endmodule

// File: tb/tb_mult32_seq.sv
// Directed bench for mult32_seq: products, latency, START-while-busy, back-to-back, mid-op reset.
// Latency: expects DONE 33 edges after the START sampling edge, BUSY for 33 cycles.
// Backpressure: none; START while BUSY must be ignored.
module tb_mult32_seq;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SnU = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BUSY;
    logic        DONE;

    int tests_run = 0;
    int tests_failed = 0;
    int overlap = 0;

    mult32_seq dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SnU   (SnU),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DONE && BUSY) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one START, then waits (bounded) for DONE. lat counts edges after E0.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic snu,
                         output int lat, output int busy_cnt, output logic [63:0] prod);
        @(negedge CLK);
        A = a; B = b; SnU = snu; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!DONE && lat < 100) begin
            if (BUSY) busy_cnt++;
            @(posedge CLK); #1;
            lat++;
        end
        prod = {HI, LO};
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        snu;
        logic [63:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, bc, dones, holds_bad;
        logic [63:0] p, cap;

        vecs[0] = '{32'd3,        32'd5,        1'b0, 64'd15,                  "u_3x5"};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001,   "u_max"};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001,   "s_m1xm1"};
        vecs[3] = '{32'hFFFFFFFE, 32'd3,        1'b1, 64'hFFFFFFFF_FFFFFFFA,   "s_m2x3"};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000,   "s_min_sq"};
        vecs[5] = '{32'hFFFFFFFF, 32'd2,        1'b0, 64'h00000001_FFFFFFFE,   "u_max_x2"};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);

        // Directed products, with latency checks on each
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].snu, lat, bc, p);
            chk(vecs[i].tag, p, vecs[i].exp);
            chk({vecs[i].tag, "_lat"}, 64'(lat), 64'd33);
            if (i == 0) begin
                chk("busy_cycles", 64'(bc), 64'd33);
                chk("busy_in_done", {63'd0, BUSY}, 64'd0);
                @(posedge CLK); #1;
                chk("done_one_cycle", {63'd0, DONE}, 64'd0);
            end
        end

        // START while BUSY: 7*9, then 100*100 pulsed at RUN cycle 10
        @(negedge CLK);
        A = 32'd7; B = 32'd9; SnU = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        dones = 0;
        cap = '0;
        for (int c = 0; c < 60; c++) begin
            if (c == 10) begin A = 32'd100; B = 32'd100; START = 1'b1; end
            if (c == 11) START = 1'b0;
            @(posedge CLK); #1;
            if (DONE) begin dones++; cap = {HI, LO}; end
        end
        chk("busy_start_prod", cap, 64'd63);
        chk("busy_start_dones", 64'(dones), 64'd1);

        // Back-to-back: 3*5 then 6*7 started in the DONE cycle
        do_op(32'd3, 32'd5, 1'b0, lat, bc, p);
        chk("b2b_first", p, 64'd15);
        A = 32'd6; B = 32'd7; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        holds_bad = 0;
        while (!DONE && lat < 100) begin
            if ({HI, LO} != 64'd15) holds_bad++;
            @(posedge CLK); #1;
            lat++;
        end
        chk("b2b_second", {HI, LO}, 64'd42);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_hold", 64'(holds_bad), 64'd0);

        // Reset during RUN at count=15
        @(negedge CLK);
        A = 32'd1000; B = 32'd1000; SnU = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midrst_hi", {32'd0, HI}, 64'd0);
        chk("midrst_lo", {32'd0, LO}, 64'd0);
        chk("midrst_busy", {63'd0, BUSY}, 64'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        do_op(32'd2, 32'd2, 1'b0, lat, bc, p);
        chk("after_rst_prod", p, 64'd4);
        chk("after_rst_lat", 64'(lat), 64'd33);

        chk("done_busy_overlap", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
